// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline: ALU op codes, register
// index constants and the packed control bundle carried between stages.
package riscv_pipe_pkg;

    localparam int ALUOP_W   = 4;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_COPY_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // True when an instruction really reads register idx and idx is rd.
    function automatic logic reads_reg(input logic                 uses,
                                       input logic [REG_IDX_W-1:0] idx,
                                       input logic [REG_IDX_W-1:0] rd);
        return uses & (idx == rd);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction currently in ID. A load into x0 never creates a dependency.
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic                 ex_valid_i,
    input  logic                 ex_mem_read_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 id_valid_i,
    input  logic                 id_uses_rs1_i,
    input  logic                 id_uses_rs2_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    output logic                 load_use_o
);

    logic ex_is_load;
    logic src_match;

    always_comb begin
        ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rd_i != REG_X0);
        src_match  = reads_reg(id_uses_rs1_i, id_rs1_i, ex_rd_i)
                   | reads_reg(id_uses_rs2_i, id_rs2_i, ex_rd_i);
        load_use_o = ex_is_load & id_valid_i & src_match;
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush, memory
// freeze and a saturating count of the bubbles inserted for load-use.
module id_ex_hazard_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = riscv_pipe_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 id_valid_i,
    input  logic [riscv_pipe_pkg::REG_IDX_W-1:0] id_rs1_i,
    input  logic [riscv_pipe_pkg::REG_IDX_W-1:0] id_rs2_i,
    input  logic [riscv_pipe_pkg::REG_IDX_W-1:0] id_rd_i,
    input  logic                                 id_uses_rs1_i,
    input  logic                                 id_uses_rs2_i,
    input  logic [XLEN-1:0]                      id_pc_i,
    input  logic [XLEN-1:0]                      id_rs1_data_i,
    input  logic [XLEN-1:0]                      id_rs2_data_i,
    input  logic [XLEN-1:0]                      id_imm_i,
    input  logic                                 id_reg_write_i,
    input  logic                                 id_mem_read_i,
    input  logic                                 id_mem_write_i,
    input  logic                                 id_mem_to_reg_i,
    input  logic                                 id_alu_src_i,
    input  logic [ALUOP_W-1:0]                   id_alu_op_i,
    input  logic                                 flush_ex_i,
    input  logic                                 mem_busy_i,
    output logic                                 stall_if_id_o,
    output logic                                 ex_valid_o,
    output logic [riscv_pipe_pkg::REG_IDX_W-1:0] ex_rs1_o,
    output logic [riscv_pipe_pkg::REG_IDX_W-1:0] ex_rs2_o,
    output logic [riscv_pipe_pkg::REG_IDX_W-1:0] ex_rd_o,
    output logic [XLEN-1:0]                      ex_pc_o,
    output logic [XLEN-1:0]                      ex_rs1_data_o,
    output logic [XLEN-1:0]                      ex_rs2_data_o,
    output logic [XLEN-1:0]                      ex_imm_o,
    output logic                                 ex_reg_write_o,
    output logic                                 ex_mem_read_o,
    output logic                                 ex_mem_write_o,
    output logic                                 ex_mem_to_reg_o,
    output logic                                 ex_alu_src_o,
    output logic [ALUOP_W-1:0]                   ex_alu_op_o,
    output logic [CNT_W-1:0]                     load_use_stall_cnt_o
);

    import riscv_pipe_pkg::*;

    localparam int CTRL_OP_W = $bits(ctrl_t) - 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        ctrl_t                ctrl;
    } ex_stage_t;

    ex_stage_t        id_stage;
    ex_stage_t        ex_q;
    ex_stage_t        ex_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_use;

    load_use_detect u_load_use_detect (
        .ex_valid_i    (ex_q.valid),
        .ex_mem_read_i (ex_q.ctrl.mem_read),
        .ex_rd_i       (ex_q.rd),
        .id_valid_i    (id_valid_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .load_use_o    (load_use)
    );

    // Gather the ID-side fields into the same shape as the EX register.
    always_comb begin
        id_stage                 = '0;
        id_stage.valid           = id_valid_i;
        id_stage.rs1             = id_rs1_i;
        id_stage.rs2             = id_rs2_i;
        id_stage.rd              = id_rd_i;
        id_stage.pc              = id_pc_i;
        id_stage.rs1_data        = id_rs1_data_i;
        id_stage.rs2_data        = id_rs2_data_i;
        id_stage.imm             = id_imm_i;
        id_stage.ctrl.reg_write  = id_reg_write_i;
        id_stage.ctrl.mem_read   = id_mem_read_i;
        id_stage.ctrl.mem_write  = id_mem_write_i;
        id_stage.ctrl.mem_to_reg = id_mem_to_reg_i;
        id_stage.ctrl.alu_src    = id_alu_src_i;
        id_stage.ctrl.alu_op     = CTRL_OP_W'(id_alu_op_i);
    end

    // Freeze beats flush beats load-use; a flushed load-use is not counted
    // because the dependent instruction is being discarded anyway.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (!mem_busy_i) begin
            if (flush_ex_i) begin
                ex_d      = '0;
                ex_d.ctrl = BUBBLE_CTRL;
            end else if (load_use) begin
                ex_d      = '0;
                ex_d.ctrl = BUBBLE_CTRL;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                ex_d = id_stage;
            end
        end
    end

    // Reset leaves a bubble in EX so nothing is pending when the pipe starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_if_id_o        = mem_busy_i | (load_use & ~flush_ex_i);

    assign ex_valid_o           = ex_q.valid;
    assign ex_rs1_o             = ex_q.rs1;
    assign ex_rs2_o             = ex_q.rs2;
    assign ex_rd_o              = ex_q.rd;
    assign ex_pc_o              = ex_q.pc;
    assign ex_rs1_data_o        = ex_q.rs1_data;
    assign ex_rs2_data_o        = ex_q.rs2_data;
    assign ex_imm_o             = ex_q.imm;
    assign ex_reg_write_o       = ex_q.ctrl.reg_write;
    assign ex_mem_read_o        = ex_q.ctrl.mem_read;
    assign ex_mem_write_o       = ex_q.ctrl.mem_write;
    assign ex_mem_to_reg_o      = ex_q.ctrl.mem_to_reg;
    assign ex_alu_src_o         = ex_q.ctrl.alu_src;
    assign ex_alu_op_o          = ALUOP_W'(ex_q.ctrl.alu_op);
    assign load_use_stall_cnt_o = cnt_q;

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core.
- Captures decoded operands and control from ID and presents them to EX and to the forwarding unit (ex_rs1/ex_rs2 drive its rs1/rs2).
- Inserts one bubble on a load-use dependency, since a load result cannot be forwarded in time.
- Honours a branch flush from EX and a whole-pipe freeze from the data memory, and keeps a saturating count of load-use stalls.

Parameters:
- XLEN, 32, datapath width.
- ALUOP_W, 4, ALU operation code width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices from decode.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded datapath values.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1 each  control bits.
- id_alu_op  in  ALUOP_W  ALU operation.
- flush_ex  in  1  branch/jump taken in EX; squash the instruction entering EX.
- mem_busy  in  1  data memory stall; freeze the whole pipe.
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op  out  same widths as the id_* inputs  registered EX-stage copies.
- load_use_stall_cnt  out  CNT_W  saturating count of inserted load-use bubbles.

Behaviour:
- Reset (rst_n low, asynchronous): every ex_* output is 0 and load_use_stall_cnt is 0. The pipe comes out of reset holding a bubble.
- Load-use detection is combinational:
  - load_use = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
  - A destination of x0 never causes a hazard.
- stall_if_id = mem_busy | (load_use & ~flush_ex).
- Register update on the rising edge of clk, first matching rule wins:
  1. mem_busy = 1: hold every ex_* field and the counter. flush_ex is ignored; EX is frozen too, so it re-asserts flush_ex once the freeze lifts.
  2. flush_ex = 1: load a bubble. The counter does not increment, even if load_use is also true.
  3. load_use = 1: load a bubble and increment the counter, saturating at 2^CNT_W - 1 (no wrap).
  4. Otherwise: load every id_* field into the matching ex_* field, including id_valid into ex_valid.
- Bubble definition:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg and ex_rd are 0, so downstream forwarding sees x0.
  - All other ex_* fields are also cleared to 0 for determinism.
- Latency: one cycle from ID to EX when not stalled. A load-use dependency costs exactly one bubble: on the next cycle ex_mem_read is 0, load_use drops, and the held ID instruction advances.
- If id_valid = 0, the stage simply registers it; no hazard is raised and no count is taken.
- A reset asserted mid-stall clears everything immediately; no pending stall survives reset.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - the ALU op encodings and ALUOP_W;
  - the register-index width constant (5);
  - the x0 index constant;
  - a packed control-bundle typedef (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op) and its BUBBLE_CTRL zero constant.
- One natural sub-module: load_use_detect. It is purely combinational, computes load_use, and is reused by any later multi-issue variant.

Test Plan:
- LW x5,0(x1) followed by ADD x6,x5,x2 -> cycle after the LW reaches EX: stall_if_id=1 and EX receives a bubble (ex_valid=0, ex_rd=0). Next cycle ADD enters EX with ex_rs1=5. load_use_stall_cnt=1.
- LW x0,0(x1) followed by ADD x6,x0,x2 -> no stall; ADD reaches EX the next cycle; counter stays 0.
- LW x5 followed by ADDI x7,x5 with id_uses_rs2=0 and id_rs2=5 -> stall via rs1 only. Repeat with id_uses_rs1=0 and id_rs1=9 -> no stall.
- Load-use condition and flush_ex=1 in the same cycle -> stall_if_id=0, bubble loaded, counter unchanged.
- mem_busy=1 for 3 cycles with a valid SUB in ID and flush_ex pulsed in the middle -> ex_* outputs are bit-identical across all 3 cycles and stall_if_id=1 throughout. After release, the SUB enters EX when flush_ex is low, or a bubble enters when flush_ex is high.
- Counter and reset, with CNT_W=2: 5 back-to-back load-use pairs -> counter reads 1, 2, 3, 3, 3. Then assert rst_n=0 mid-stall -> all ex_* outputs and the counter go to 0 immediately, without waiting for a clock edge.
